// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
//
// Stream-to-RAM writer for the complex matrix-product datapath. One 32-bit
// valid/ready word stream is scattered into the four operand RAMs in plane
// order R1, I1, R2, I2. Each plane holds DIM*DIM words in row-major order.
// Once the last I2 word has been written, a one-cycle start_op pulse is sent
// to the operation-signal state machine.
//
// Write timing: a word accepted in cycle t shows up on wdata/waddr with its
// plane's write enable in cycle t+1. start_op follows two cycles after the
// final handshake.
//
// Optional feature macro: MATRIX_LOADER_CHECKSUM_EN
//   defined   -> checksum is a wrap-around sum of every accepted word. It is
//                cleared when a load is accepted.
//   undefined -> no checksum register is built, and checksum is tied to 0.
//
// Ports
//   clk       in   slow clock shared with the operand RAMs
//   rst       in   asynchronous reset, active-high
//   load      in   request a full load (only honoured in IDLE or DONE)
//   s_data    in   stream word (Q5.27, passed through unchanged)
//   s_valid   in   stream word valid
//   s_ready   out  loader accepts a word this cycle (high only in LOAD)
//   wdata     out  RAM write data, shared by all four RAMs
//   waddr     out  RAM write address, shared
//   we_r1     out  write enable, RAM R1
//   we_i1     out  write enable, RAM I1
//   we_r2     out  write enable, RAM R2
//   we_i2     out  write enable, RAM I2
//   start_op  out  one-cycle pulse to the operation-signal FSM
//   busy      out  high in LOAD, LAST and START
//   done      out  high in DONE
//   checksum  out  running sum of accepted words (see macro above)
//
// States
//   IDLE  | waiting for the first load request after reset
//   LOAD  | accepting stream words and issuing RAM writes
//   LAST  | final I2 write in flight, stream stalled
//   START | start_op pulse to the product core
//   DONE  | all four planes written; load re-arms
// -----------------------------------------------------------------------------
module matrix_loader #(
    parameter int ANCHO_PALABRA = 32,
    parameter int DIM           = 3,
    parameter int ADDR_W        = $clog2(DIM*DIM-1)+1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [ANCHO_PALABRA-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [ANCHO_PALABRA-1:0] wdata,
    output logic [ADDR_W-1:0]        waddr,
    output logic                     we_r1,
    output logic                     we_i1,
    output logic                     we_r2,
    output logic                     we_i2,
    output logic                     start_op,
    output logic                     busy,
    output logic                     done,
    output logic [ANCHO_PALABRA-1:0] checksum
);

    localparam int                WORDS    = DIM*DIM;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(WORDS-1);

    typedef enum logic [2:0] {IDLE, LOAD, LAST, START, DONE} state_t;
    typedef enum logic [1:0] {PL_R1, PL_I1, PL_R2, PL_I2} plane_t;

    state_t                   state_q;
    plane_t                   plane_q;
    plane_t                   plane_d;
    logic [ADDR_W-1:0]        idx_q;
    logic [ADDR_W-1:0]        idx_d;
    logic [ANCHO_PALABRA-1:0] wdata_q;
    logic [ADDR_W-1:0]        waddr_q;
    logic [3:0]               we_q;      // {I2, R2, I1, R1}
    logic                     start_q;

    logic handshake;
    logic idx_wrap;
    logic final_word;
    logic load_accept;

    always_comb begin
        handshake   = s_valid && (state_q == LOAD);
        load_accept = load && ((state_q == IDLE) || (state_q == DONE));
        idx_wrap    = (idx_q == IDX_LAST);
        final_word  = idx_wrap && (plane_q == PL_I2);
        idx_d       = idx_wrap ? '0 : idx_q + ADDR_W'(1);
        plane_d     = idx_wrap ? plane_t'(plane_q + 2'd1) : plane_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            plane_q <= PL_R1;
            idx_q   <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            we_q    <= '0;
            start_q <= 1'b0;
        end else begin
            // Write enables and start_op are single-cycle pulses unless re-armed below.
            we_q    <= '0;
            start_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (load) begin
                        state_q <= LOAD;
                        plane_q <= PL_R1;
                        idx_q   <= '0;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        wdata_q <= s_data;
                        waddr_q <= idx_q;
                        we_q    <= 4'b0001 << plane_q;
                        idx_q   <= idx_d;
                        plane_q <= plane_d;
                        if (final_word) begin
                            state_q <= LAST;
                        end
                    end
                end
                LAST: begin
                    start_q <= 1'b1;
                    state_q <= START;
                end
                START: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [ANCHO_PALABRA-1:0] csum_q;
    logic [ANCHO_PALABRA-1:0] csum_d;

    always_comb begin
        csum_d = csum_q;
        if (load_accept) begin
            csum_d = '0;
        end else if (handshake) begin
            csum_d = csum_q + s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    // Status outputs are decoded straight from the state register.
    assign s_ready  = (state_q == LOAD);
    assign busy     = (state_q == LOAD) || (state_q == LAST) || (state_q == START);
    assign done     = (state_q == DONE);

    assign wdata    = wdata_q;
    assign waddr    = waddr_q;
    assign we_r1    = we_q[0];
    assign we_i1    = we_q[1];
    assign we_r2    = we_q[2];
    assign we_i2    = we_q[3];
    assign start_op = start_q;

    a_we_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(we_q));
    a_waddr_range : assert property (@(posedge clk) disable iff (rst) waddr_q <= IDX_LAST);

endmodule
